// File: rtl/key_event.sv
// rtl/key_event.sv - key gesture decoder: short, long, double click and auto-repeat pulses.
// Optional auto-repeat while held is enabled by defining KEY_EVENT_REPEAT_EN.
module key_event #(
   parameter logic ACTIVE_LOW = 1'b1,
   parameter int   LONG_MS    = 1000,
   parameter int   DBL_MS     = 300,
   parameter int   REPEAT_MS  = 200
) (
   input  logic CLK1K,
   input  logic RSTN,
   input  logic KEY_IN,
   output logic SHORT_P,
   output logic LONG_P,
   output logic DOUBLE_P,
   output logic REPEAT_P,
   output logic BUSY
);

   typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HELD} state_t;

   localparam logic [10:0] LONG_LAST = 11'(LONG_MS - 1);
   localparam logic [10:0] DBL_LAST  = 11'(DBL_MS - 1);
   localparam logic [10:0] CNT_MAX   = 11'h7FF;

   if (LONG_MS < 2 || LONG_MS > 2047 || DBL_MS < 2 || DBL_MS > 2047 ||
       REPEAT_MS < 2 || REPEAT_MS > 2047) begin : g_bad_param
      $error("key_event: timing parameters must lie in 2..2047");
   end

   state_t      state_q, state_d;
   logic [10:0] cnt_q, cnt_d, cnt_inc;
   logic        prev_q;
   logic        short_q, short_d;
   logic        long_q, long_d;
   logic        double_q, double_d;
   logic        busy_q;
   logic        pressed, press_edge;

   assign pressed    = KEY_IN ^ ACTIVE_LOW;
   assign press_edge = pressed & ~prev_q;
   assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 11'd1;

`ifdef KEY_EVENT_REPEAT_EN
   localparam logic [10:0] REP_LAST = 11'(REPEAT_MS - 1);
   logic repeat_q, repeat_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_inc;
      short_d  = 1'b0;
      long_d   = 1'b0;
      double_d = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (press_edge) state_d = PRESS1;
         end
         PRESS1: begin
            if (!pressed) begin
               state_d = WAIT2;
            end else if (cnt_q == LONG_LAST) begin
               state_d = HELD;
               long_d  = 1'b1;
            end
         end
         WAIT2: begin
            if (press_edge) begin
               state_d = PRESS2;
            end else if (cnt_q == DBL_LAST) begin
               state_d = IDLE;
               short_d = 1'b1;
            end
         end
         PRESS2: begin
            if (!pressed) begin
               state_d  = IDLE;
               double_d = 1'b1;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_d = IDLE;
`ifdef KEY_EVENT_REPEAT_EN
            end else if (cnt_q == REP_LAST) begin
               repeat_d = 1'b1;
               cnt_d    = '0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      // Every transition restarts the timer for the state being entered.
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge CLK1K or negedge RSTN) begin
      if (!RSTN) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         prev_q   <= 1'b1;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prev_q   <= pressed;
         short_q  <= short_d;
         long_q   <= long_d;
         double_q <= double_d;
         busy_q   <= (state_d != IDLE);
      end
   end

`ifdef KEY_EVENT_REPEAT_EN
   always_ff @(posedge CLK1K or negedge RSTN) begin
      if (!RSTN) repeat_q <= 1'b0;
      else       repeat_q <= repeat_d;
   end
   assign REPEAT_P = repeat_q;
`else
   assign REPEAT_P = 1'b0;
`endif

   assign SHORT_P  = short_q;
   assign LONG_P   = long_q;
   assign DOUBLE_P = double_q;
   assign BUSY     = busy_q;

endmodule

// File: tb/tb_key_event.sv
// tb/tb_key_event.sv - directed bench for key_event with a timestamp-based gesture model.
module tb_key_event;

   localparam int LONG_MS   = 20;
   localparam int DBL_MS    = 8;
   localparam int REPEAT_MS = 5;

   logic clk = 1'b0;
   logic rstn;
   logic key_in;
   logic short_p, long_p, double_p, repeat_p, busy;

   key_event #(
      .ACTIVE_LOW (1'b1),
      .LONG_MS    (LONG_MS),
      .DBL_MS     (DBL_MS),
      .REPEAT_MS  (REPEAT_MS)
   ) dut (
      .CLK1K    (clk),
      .RSTN     (rstn),
      .KEY_IN   (key_in),
      .SHORT_P  (short_p),
      .LONG_P   (long_p),
      .DOUBLE_P (double_p),
      .REPEAT_P (repeat_p),
      .BUSY     (busy)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Gesture model: phase plus the cycle stamp at which the phase was entered.
   localparam int M_IDLE = 0, M_P1 = 1, M_W2 = 2, M_P2 = 3, M_HELD = 4;
   int   m_phase = M_IDLE;
   int   m_t0    = 0;
   logic m_prev  = 1'b1;
   logic e_short, e_long, e_double, e_repeat, e_busy;

   int n_short = 0, n_long = 0, n_double = 0, n_repeat = 0;
   int t_short = -1, t_long = -1, t_double = -1;
   int t_rep [2];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model(input logic p);
      logic edge_seen;
      edge_seen = p && !m_prev;
      e_short = 0; e_long = 0; e_double = 0; e_repeat = 0;
      case (m_phase)
         M_IDLE: if (edge_seen) begin m_phase = M_P1; m_t0 = cyc; end
         M_P1: begin
            if (!p) begin m_phase = M_W2; m_t0 = cyc; end
            else if (cyc - m_t0 == LONG_MS) begin m_phase = M_HELD; m_t0 = cyc; e_long = 1; end
         end
         M_W2: begin
            if (edge_seen) m_phase = M_P2;
            else if (cyc - m_t0 == DBL_MS) begin m_phase = M_IDLE; e_short = 1; end
         end
         M_P2: if (!p) begin m_phase = M_IDLE; e_double = 1; end
         default: begin
            if (!p) m_phase = M_IDLE;
`ifdef KEY_EVENT_REPEAT_EN
            else if (cyc - m_t0 == REPEAT_MS) begin e_repeat = 1; m_t0 = cyc; end
`endif
         end
      endcase
      e_busy = (m_phase != M_IDLE);
      m_prev = p;
   endtask

   task automatic step(input logic k);
      key_in = k;
      @(posedge clk);
      cyc++;
      model(!k);
      #1;
      check("SHORT_P",  int'(short_p),  int'(e_short));
      check("LONG_P",   int'(long_p),   int'(e_long));
      check("DOUBLE_P", int'(double_p), int'(e_double));
      check("REPEAT_P", int'(repeat_p), int'(e_repeat));
      check("BUSY",     int'(busy),     int'(e_busy));
      if (short_p)  begin n_short++;  t_short  = cyc; end
      if (long_p)   begin n_long++;   t_long   = cyc; end
      if (double_p) begin n_double++; t_double = cyc; end
      if (repeat_p) begin
         if (n_repeat < 2) t_rep[n_repeat] = cyc;
         n_repeat++;
      end
   endtask

   task automatic hold(input logic k, input int n);
      for (int i = 0; i < n; i++) step(k);
   endtask

   task automatic clear_counts();
      n_short = 0; n_long = 0; n_double = 0; n_repeat = 0;
      t_short = -1; t_long = -1; t_double = -1;
   endtask

   task automatic apply_reset(input logic k);
      key_in = k;
      rstn   = 1'b0;
      #1;
      check("rst SHORT_P",  int'(short_p),  0);
      check("rst LONG_P",   int'(long_p),   0);
      check("rst DOUBLE_P", int'(double_p), 0);
      check("rst REPEAT_P", int'(repeat_p), 0);
      check("rst BUSY",     int'(busy),     0);
      m_phase = M_IDLE;
      m_prev  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst hold BUSY", int'(busy), 0);
      rstn = 1'b1;
   endtask

   int t_ref;

   initial begin
      rstn   = 1'b1;
      key_in = 1'b1;
      #2;
      apply_reset(1'b1);
      hold(1'b1, 3);

      // Short click: one SHORT_P, DBL_MS cycles after the release is sampled.
      clear_counts();
      hold(1'b0, 5);
      t_ref = cyc + 1;
      hold(1'b1, 15);
      check("A short count", n_short, 1);
      check("A short delay", t_short - t_ref, 8);
      check("A busy after", int'(busy), 0);

      // Long press with optional auto-repeat.
      clear_counts();
      t_ref = cyc + 1;
      hold(1'b0, 32);
      hold(1'b1, 12);
      check("B long count", n_long, 1);
      check("B long delay", t_long - t_ref, 20);
      check("B no short", n_short, 0);
`ifdef KEY_EVENT_REPEAT_EN
      check("B repeat count", n_repeat, 2);
      check("B repeat1", t_rep[0] - t_long, 5);
      check("B repeat2", t_rep[1] - t_long, 10);
`else
      check("B repeat count", n_repeat, 0);
`endif

      // Double click.
      clear_counts();
      hold(1'b0, 3);
      hold(1'b1, 4);
      hold(1'b0, 3);
      t_ref = cyc + 1;
      hold(1'b1, 12);
      check("C double count", n_double, 1);
      check("C double time", t_double - t_ref, 0);
      check("C no short", n_short, 0);

      // Press edge on the last gap cycle still wins over the timeout.
      clear_counts();
      hold(1'b0, 3);
      hold(1'b1, 8);
      hold(1'b0, 40);
      hold(1'b1, 12);
      check("D double count", n_double, 1);
      check("D no short", n_short, 0);
      check("D no long", n_long, 0);

      // Gap one cycle too long: timeout short, then the next press is a fresh click.
      clear_counts();
      hold(1'b0, 3);
      t_ref = cyc + 1;
      hold(1'b1, 9);
      check("E first short", t_short - t_ref, 8);
      hold(1'b0, 3);
      hold(1'b1, 12);
      check("E short count", n_short, 2);
      check("E no double", n_double, 0);

      // Key held through reset release: silent until released and pressed again.
      apply_reset(1'b0);
      clear_counts();
      hold(1'b0, 50);
      check("F held busy", int'(busy), 0);
      hold(1'b1, 3);
      hold(1'b0, 3);
      hold(1'b1, 12);
      check("F short count", n_short, 1);
      check("F no long", n_long, 0);

      // Reset in the double-click gap discards the pending short.
      clear_counts();
      hold(1'b0, 3);
      hold(1'b1, 3);
      check("G busy in gap", int'(busy), 1);
      apply_reset(1'b1);
      hold(1'b1, 15);
      check("G no short", n_short, 0);
      check("G no double", n_double, 0);
      check("G busy", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
